// File: rtl/irq_ctrl.sv
// Interrupt controller: up to 8 low-true sources, synchronized, with STATUS/MASK/EDGE/VECTOR registers.
// Optional falling-edge latching is built only when IRQ_CTRL_EDGE_EN is defined.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs_n,
    input  logic            we_n,
    input  logic [1:0]      rs,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    input  logic [NSRC-1:0] src_n,
    output logic            irq_n
);

    localparam logic [1:0] RS_STATUS = 2'd0;
    localparam logic [1:0] RS_MASK   = 2'd1;
    localparam logic [1:0] RS_EDGE   = 2'd2;
    localparam logic [1:0] RS_VECTOR = 2'd3;

    logic [NSRC-1:0] s1_q, s2_q;
    logic [NSRC-1:0] lat_q, lat_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_w;
    logic [NSRC-1:0] edge_set;
    logic            irq_n_q;
    logic [7:0]      dout_q, dout_d;

    logic            wr;
    logic [NSRC-1:0] wdat;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pm;
    logic            any;
    logic [2:0]      idx;

    assign wr   = ~cs_n & ~we_n;
    assign wdat = din[NSRC-1:0];

    // Two-flop synchronizer; idle (high) value out of reset so nothing looks asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= src_n;
            s2_q <= s1_q;
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [NSRC-1:0] edge_q, edge_d;
    logic [NSRC-1:0] prev_q;

    // prev_q tracks s2 unconditionally, so enabling EDGE later never sees a stale edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '1;
            edge_q <= '0;
        end else begin
            prev_q <= s2_q;
            edge_q <= edge_d;
        end
    end

    always_comb begin
        edge_d = edge_q;
        if (wr && rs == RS_EDGE)
            edge_d = wdat;
    end

    assign edge_w   = edge_q;
    assign edge_set = edge_q & ~s2_q & prev_q;
`else
    assign edge_w   = '0;
    assign edge_set = '0;
`endif

    assign pend = lat_q | (~s2_q & ~edge_w);
    assign pm   = pend & mask_q;
    assign any  = |pm;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pm[i])
                idx = i[2:0];
        end
    end

    always_comb begin
        lat_d  = lat_q;
        mask_d = mask_q;
        if (wr && rs == RS_STATUS)
            lat_d = lat_q & ~wdat;
        if (wr && rs == RS_MASK)
            mask_d = wdat;
        // Sets are applied after the clear so they win on a collision.
        lat_d = lat_d | edge_set;
        if (wr && rs == RS_VECTOR)
            lat_d = lat_d | wdat;
    end

    always_comb begin
        dout_d = 8'h00;
        case (rs)
            RS_STATUS: dout_d[NSRC-1:0] = pend;
            RS_MASK:   dout_d[NSRC-1:0] = mask_q;
            RS_EDGE:   dout_d[NSRC-1:0] = edge_w;
            RS_VECTOR: dout_d = {any, 4'b0000, idx};
            default:   dout_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_q   <= '0;
            mask_q  <= '0;
            irq_n_q <= 1'b1;
            dout_q  <= 8'h00;
        end else begin
            lat_q   <= lat_d;
            mask_q  <= mask_d;
            irq_n_q <= ~any;
            dout_q  <= dout_d;
        end
    end

    assign irq_n = irq_n_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; edge-mode steps run only when IRQ_CTRL_EDGE_EN is defined.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs_n, we_n;
    logic [1:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] src_n;
    logic       irq_n;

    int tests = 0;
    int fails = 0;

    irq_ctrl #(.NSRC(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs_n    (cs_n),
        .we_n    (we_n),
        .rs      (rs),
        .din     (din),
        .dout    (dout),
        .src_n   (src_n),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; we_n = 1'b0; rs = r; din = d;
        @(negedge clk);
        cs_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] r, input logic [7:0] exp);
        @(negedge clk);
        rs = r;
        @(negedge clk);
        check(tag, dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {7'b0, irq_n}, {7'b0, exp});
    endtask

    initial begin
        reset_n = 1'b0;
        cs_n = 1'b1; we_n = 1'b1; rs = 2'd0; din = 8'h00; src_n = 8'hFF;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        chk_irq("rst_irq", 1'b1);
        rd_chk("rst_status", 2'd0, 8'h00);
        rd_chk("rst_mask",   2'd1, 8'h00);
        rd_chk("rst_edge",   2'd2, 8'h00);
        rd_chk("rst_vector", 2'd3, 8'h00);

        // Level source 0: 3-edge latency, survives STATUS clear
        wr_reg(2'd1, 8'h01);
        rd_chk("mask_rb", 2'd1, 8'h01);
        @(negedge clk); src_n[0] = 1'b0;
        @(negedge clk); chk_irq("lvl_e1", 1'b1);
        @(negedge clk); chk_irq("lvl_e2", 1'b1);
        @(negedge clk); chk_irq("lvl_e3", 1'b0);
        rd_chk("lvl_vector", 2'd3, 8'h80);
        wr_reg(2'd0, 8'h01);
        rd_chk("lvl_status_after_w1c", 2'd0, 8'h01);
        chk_irq("lvl_still_low", 1'b0);
        @(negedge clk); src_n[0] = 1'b1;
        @(negedge clk);
        @(negedge clk); chk_irq("lvl_rel_e2", 1'b0);
        @(negedge clk); chk_irq("lvl_rel_e3", 1'b1);
        rd_chk("lvl_status_idle", 2'd0, 8'h00);

`ifdef IRQ_CTRL_EDGE_EN
        // Edge source 2: 1-cycle pulse latched, 4-edge latency
        wr_reg(2'd2, 8'h04);
        wr_reg(2'd1, 8'h04);
        rd_chk("edge_rb", 2'd2, 8'h04);
        @(negedge clk); src_n[2] = 1'b0;
        @(negedge clk); src_n[2] = 1'b1; chk_irq("edg_e1", 1'b1);
        @(negedge clk); chk_irq("edg_e2", 1'b1);
        @(negedge clk); chk_irq("edg_e3", 1'b1);
        @(negedge clk); chk_irq("edg_e4", 1'b0);
        rd_chk("edg_status", 2'd0, 8'h04);
        rd_chk("edg_vector", 2'd3, 8'h82);
        wr_reg(2'd0, 8'h04);
        chk_irq("edg_clr_same", 1'b0);
        @(negedge clk); chk_irq("edg_clr_next", 1'b1);
        rd_chk("edg_status_clr", 2'd0, 8'h00);

        // W1C on the same edge that latches a new fall: set wins
        @(negedge clk); src_n[2] = 1'b0;
        @(negedge clk); src_n[2] = 1'b1;
        @(negedge clk); cs_n = 1'b0; we_n = 1'b0; rs = 2'd0; din = 8'h04;
        @(negedge clk); cs_n = 1'b1; we_n = 1'b1;
        rd_chk("collide_status", 2'd0, 8'h04);
        wr_reg(2'd0, 8'h04);
        wr_reg(2'd2, 8'h00);
        rd_chk("collide_cleared", 2'd0, 8'h00);
`else
        // Without edge support EDGE is read-only zero and sources stay level
        wr_reg(2'd2, 8'hFF);
        rd_chk("edge_ignored", 2'd2, 8'h00);
        @(negedge clk); src_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk("noedge_level_status", 2'd0, 8'h02);
        @(negedge clk); src_n[1] = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk("noedge_level_gone", 2'd0, 8'h00);
`endif

        // VECTOR-write sets, priority encode, selective clear
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd3, 8'h28);
        rd_chk("vec_status", 2'd0, 8'h28);
        rd_chk("vec_vector", 2'd3, 8'h83);
        wr_reg(2'd0, 8'h08);
        rd_chk("vec_vector_clr", 2'd3, 8'h85);
        chk_irq("vec_irq", 1'b0);

        // Asynchronous reset mid-operation
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        chk_irq("arst_irq", 1'b1);
        check("arst_dout", dout, 8'h00);
        @(negedge clk); reset_n = 1'b1;
        rd_chk("arst_status", 2'd0, 8'h00);
        rd_chk("arst_mask",   2'd1, 8'h00);
        rd_chk("arst_edge",   2'd2, 8'h00);
        rd_chk("arst_vector", 2'd3, 8'h00);
        chk_irq("arst_irq_after", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
